// File: rtl/hc_logic_pkg.sv
// Shared definitions for the hc_ '16x-family counter blocks.
// Direction encoding and the load clamp live here so sibling blocks stay consistent.
package hc_logic_pkg;

    localparam logic HC_UP   = 1'b1;
    localparam logic HC_DOWN = 1'b0;

    // Loaded data never leaves 0..modulus-1; out-of-range values pin to the top count.
    function automatic logic [63:0] hc_clamp(input logic [63:0] value, input logic [63:0] modulus);
        return (value >= modulus) ? (modulus - 64'd1) : value;
    endfunction

endpackage

// File: rtl/hc_term_detect.sv
// Terminal-state decode for a modulo-MODULUS counter.
// Shared by the combinational TC output and the registered wrap pulse.
module hc_term_detect #(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    assign at_max  = (q == MAX_VAL);
    assign at_zero = (q == '0);

endmodule

// File: rtl/hc_counter_mod.sv
// Parametrised up/down modulo-N counter with '161-style CEP/CET/PEN pins,
// synchronous clear, clamped parallel load, cascadable TC and registered wrap pulse RC.
module hc_counter_mod
    import hc_logic_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             SRN,
    input  logic             PEN,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UD,
    input  logic [WIDTH-1:0] Dn,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             RC
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    if ((WIDTH < 2) || (WIDTH > 32) || (MODULUS < 2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_params
        $error("hc_counter_mod: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] qn_q, qn_d;
    logic             rc_q, rc_d;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] load_val;

    hc_term_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_term_detect (
        .q       (qn_q),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    assign load_val = WIDTH'(hc_clamp(64'(Dn), 64'(MODULUS)));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        qn_d = qn_q;
        rc_d = 1'b0;
        if (!SRN) begin
            qn_d = '0;
        end else if (!PEN) begin
            qn_d = load_val;
        end else if (CEP && CET) begin
            if (UD == HC_UP) begin
                if (at_max) begin
                    qn_d = '0;
                    rc_d = 1'b1;
                end else begin
                    qn_d = qn_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    qn_d = MAX_VAL;
                    rc_d = 1'b1;
                end else begin
                    qn_d = qn_q - ONE;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            qn_q <= '0;
            rc_q <= 1'b0;
        end else begin
            qn_q <= qn_d;
            rc_q <= rc_d;
        end
    end

    // TC ignores CEP/PEN/SRN so a cascade stays valid while stages are loading.
    assign TC = CET & (((UD == HC_UP) & at_max) | ((UD == HC_DOWN) & at_zero));
    assign Qn = qn_q;
    assign RC = rc_q;

endmodule

// File: tb/tb_hc_counter_mod.sv
// Self-checking bench: two cascaded MODULUS=10 stages against a behavioural scoreboard.
// Stage 1 shares every input with stage 0 except CET, which is stage 0's TC.
module tb_hc_counter_mod;

    logic       cp = 1'b0;
    logic       mr, srn, pen, cep, cet, ud;
    logic [3:0] dn;
    logic [3:0] q0, q1;
    logic       tc0, tc1, rc0, rc1;

    int n_cmp = 0;
    int n_bad = 0;

    int m_q0 = 0, m_q1 = 0;
    bit m_rc0 = 1'b0, m_rc1 = 1'b0;

    typedef struct {
        string      tag;
        logic [3:0] q0;
        logic       tc0;
        logic       rc0;
        logic [3:0] q1;
        logic       tc1;
        logic       rc1;
    } exp_t;

    exp_t sb[$];

    hc_counter_mod #(.WIDTH(4), .MODULUS(10)) u_stage0 (
        .CP(cp), .MR(mr), .SRN(srn), .PEN(pen), .CEP(cep), .CET(cet), .UD(ud),
        .Dn(dn), .Qn(q0), .TC(tc0), .RC(rc0)
    );

    hc_counter_mod #(.WIDTH(4), .MODULUS(10)) u_stage1 (
        .CP(cp), .MR(mr), .SRN(srn), .PEN(pen), .CEP(cep), .CET(tc0), .UD(ud),
        .Dn(dn), .Qn(q1), .TC(tc1), .RC(rc1)
    );

    always #5 cp = ~cp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_tc(int q, bit cet_i, bit ud_i);
        return cet_i && ((ud_i && q == 9) || (!ud_i && q == 0));
    endfunction

    task automatic m_next(input int q, input bit cet_i, output int nq, output bit nrc);
        nq  = q;
        nrc = 1'b0;
        if (!srn) begin
            nq = 0;
        end else if (!pen) begin
            nq = (dn > 4'd9) ? 9 : int'(dn);
        end else if (cep && cet_i) begin
            if (ud) begin
                if (q == 9) begin nq = 0; nrc = 1'b1; end
                else nq = q + 1;
            end else begin
                if (q == 0) begin nq = 9; nrc = 1'b1; end
                else nq = q - 1;
            end
        end
    endtask

    // Compares live outputs with the model between edges (combinational / async paths).
    task automatic check_now(input string tag);
        bit t0;
        t0 = m_tc(m_q0, cet, ud);
        check({tag, " q0"},  32'(q0),  32'(m_q0));
        check({tag, " tc0"}, 32'(tc0), 32'(t0));
        check({tag, " rc0"}, 32'(rc0), 32'(m_rc0));
        check({tag, " q1"},  32'(q1),  32'(m_q1));
        check({tag, " tc1"}, 32'(tc1), 32'(m_tc(m_q1, t0, ud)));
        check({tag, " rc1"}, 32'(rc1), 32'(m_rc1));
    endtask

    // Called just after a falling edge: predict, push, clock once, pop and compare.
    task automatic step(input string tag);
        exp_t e;
        bit   t0, r0, r1;
        int   n0, n1;
        t0 = m_tc(m_q0, cet, ud);
        m_next(m_q0, cet, n0, r0);
        m_next(m_q1, t0, n1, r1);
        m_q0 = n0; m_rc0 = r0;
        m_q1 = n1; m_rc1 = r1;
        e.tag = tag;
        e.q0  = 4'(n0);
        e.rc0 = r0;
        e.tc0 = m_tc(n0, cet, ud);
        e.q1  = 4'(n1);
        e.rc1 = r1;
        e.tc1 = m_tc(n1, e.tc0, ud);
        sb.push_back(e);
        @(posedge cp);
        @(negedge cp);
        e = sb.pop_front();
        check({e.tag, " q0"},  32'(q0),  32'(e.q0));
        check({e.tag, " tc0"}, 32'(tc0), 32'(e.tc0));
        check({e.tag, " rc0"}, 32'(rc0), 32'(e.rc0));
        check({e.tag, " q1"},  32'(q1),  32'(e.q1));
        check({e.tag, " tc1"}, 32'(tc1), 32'(e.tc1));
        check({e.tag, " rc1"}, 32'(rc1), 32'(e.rc1));
    endtask

    task automatic pulse_mr(input string tag);
        #1 mr = 1'b1;
        #1;
        m_q0 = 0; m_q1 = 0; m_rc0 = 1'b0; m_rc1 = 1'b0;
        check_now(tag);
        check({tag, " lit q0"}, 32'(q0), 32'd0);
        check({tag, " lit rc0"}, 32'(rc0), 32'd0);
        mr = 1'b0;
    endtask

    initial begin
        mr = 1'b1; srn = 1'b1; pen = 1'b1; cep = 1'b0; cet = 1'b1; ud = 1'b1; dn = 4'd0;

        // Reset state and reset-time TC for both directions.
        repeat (2) @(negedge cp);
        check_now("reset up");
        check("reset tc0 up", 32'(tc0), 32'd0);
        ud = 1'b0;
        #1;
        check_now("reset down");
        check("reset tc0 down", 32'(tc0), 32'd1);
        ud = 1'b1;
        @(negedge cp);
        mr = 1'b0;

        // Count up 0..9, 0, 1.
        cep = 1'b1; cet = 1'b1; ud = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step($sformatf("up edge%0d", i));
            if (i == 9)  check("up lit tc at 9", 32'(tc0), 32'd1);
            if (i == 10) check("up lit rc after wrap", 32'(rc0), 32'd1);
            if (i == 11) check("up lit rc one cycle", 32'(rc0), 32'd0);
        end

        // Load 2 then count down through the 0-to-9 wrap.
        ud = 1'b0; pen = 1'b0; dn = 4'd2;
        step("down load2");
        pen = 1'b1;
        for (int i = 1; i <= 4; i++) step($sformatf("down edge%0d", i));
        check("down lit q0", 32'(q0), 32'd8);

        // Clamp and clear-over-load priority.
        pen = 1'b0; dn = 4'd13;
        step("clamp13");
        check("clamp lit q0", 32'(q0), 32'd9);
        check("clamp lit rc0", 32'(rc0), 32'd0);
        srn = 1'b0; dn = 4'd5;
        step("clear over load");
        check("clear lit q0", 32'(q0), 32'd0);
        srn = 1'b1; pen = 1'b1;

        // Two-stage cascade from 00 for 100 edges.
        srn = 1'b0;
        step("cascade clear");
        srn = 1'b1; ud = 1'b1; cep = 1'b1; cet = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step($sformatf("cascade edge%0d", i));
            if (i == 99) begin
                check("cascade lit 99", 32'(q1) * 10 + 32'(q0), 32'd99);
                check("cascade lit tc1 99", 32'(tc1), 32'd1);
            end
            if (i == 100) check("cascade lit 00", 32'(q1) * 10 + 32'(q0), 32'd0);
        end

        // Async reset while RC is high, then while mid-count.
        ud = 1'b0;
        step("pre-mr wrap");
        check("pre-mr lit rc0", 32'(rc0), 32'd1);
        pulse_mr("mr rc high");
        ud = 1'b1;
        step("resume after mr");
        for (int i = 0; i < 6; i++) step($sformatf("to seven%0d", i));
        check("at seven lit", 32'(q0), 32'd7);
        pulse_mr("mr at seven");
        step("resume after mr2");

        // Enable gating at 9 and same-cycle TC response to CET/UD.
        for (int i = 0; i < 8; i++) step($sformatf("to nine%0d", i));
        cep = 1'b0;
        step("hold cep0 a");
        step("hold cep0 b");
        check("hold lit q0", 32'(q0), 32'd9);
        check("hold lit tc0", 32'(tc0), 32'd1);
        cet = 1'b0;
        #1;
        check_now("cet0 now");
        check("cet0 lit tc0", 32'(tc0), 32'd0);
        step("hold cet0");
        cet = 1'b1; ud = 1'b0;
        #1;
        check_now("ud flip down");
        ud = 1'b1;
        #1;
        check_now("ud flip up");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
